sysahb_uart_tx: RTL
===================

Name: sysahb_uart_tx

Overview:
- Transmit-only UART and AHB-Lite slave on the E902 system bus, downstream of the core's biu_pad_* system AHB port.
- Buffers bytes written by the CPU in a small FIFO and serialises them 8N1 onto a pad.
- Raises a level interrupt that feeds one bit of pad_vic_int_vld.
- Runs on sys_clk; console/debug output for firmware.

Parameters:
FIFO_DEPTH, 8, TX FIFO entries; power of two, 2..64
BAUD_DIV_RST, 66, reset value of BAUD register; bit period = BAUD+1 sys_clk cycles (7.714 MHz / 67 ≈ 115200 baud)

Ports:
sys_clk  in  1  system clock
sys_resetn  in  1  synchronous active-low reset
sysahb_hsel  in  1  slave select from system bus decoder
sysahb_haddr  in  32  address; only [3:2] decoded
sysahb_htrans  in  2  transfer type; NONSEQ/SEQ when bit1=1
sysahb_hwrite  in  1  1=write
sysahb_hsize  in  3  ignored; all accesses treated as 32-bit
sysahb_hwdata  in  32  write data (data phase)
sysahb_hrdata  out  32  read data (data phase)
sysahb_hready  out  1  transfer done; always 1
sysahb_hresp  out  1  always 0 (OKAY)
uart_txd  out  1  serial output, idle high
uart_irq  out  1  level interrupt, active high

Behaviour:
- Clock and reset: one clock, sys_clk. Reset sys_resetn is synchronous and active-low. All state is sampled on the sys_clk rising edge only.
- Reset values:
  - uart_txd=1, uart_irq=0, sysahb_hrdata=0.
  - FIFO empty, FSM IDLE, CTRL=0, BAUD=BAUD_DIV_RST, OVF=0.
- AHB:
  - Address phase is accepted when hsel & htrans[1] & hready.
  - haddr[3:2] and hwrite are latched into a data-phase register. Zero wait states.
  - Writes commit at the end of the data phase using hwdata.
  - Reads drive hrdata combinationally from the latched address during the data phase; hrdata is 0 otherwise.
  - Back-to-back transfers are supported.
- Register map:
  - 0x0 DATA:
    - Write pushes hwdata[7:0].
    - If the FIFO is full, the push is dropped and OVF is set.
    - Read returns 0.
  - 0x4 STATUS (read-only; OVF is write-1-to-clear):
    - bit0 full, bit1 empty, bit2 busy (FSM≠IDLE), bit3 OVF.
    - bits[15:8] FIFO count.
  - 0x8 BAUD: bits[15:0], RW.
  - 0xC CTRL: bit0 tx_en, bit1 irq_en, RW.
- Full-check and pop in the same cycle: fullness is evaluated before the pop. A push to a full FIFO is dropped even if a pop occurs that cycle.
- Push and pop in the same non-full, non-empty cycle: count is unchanged.
- FSM states IDLE → START → DATA → STOP → IDLE:
  - IDLE: when tx_en & !empty, pop the head into the shift register, load the bit counter with BAUD, go to START.
  - START: txd=0 for BAUD+1 cycles.
  - DATA: 8 bits LSB first, each BAUD+1 cycles.
  - STOP: txd=1 for BAUD+1 cycles. Then IDLE, or START directly if tx_en & !empty (pop in that cycle).
  - First start bit appears on uart_txd 1 cycle after the pop.
- BAUD is sampled at each bit start, so a mid-frame write takes effect at the next bit. BAUD=0 gives 1 cycle per bit.
- Clearing tx_en mid-frame completes the current frame, then the FSM holds in IDLE.
- uart_irq (registered) = irq_en & empty & (FSM==IDLE), i.e. "transmitter drained".
- Reset mid-frame: uart_txd=1 on the next edge, FIFO flushed, no partial completion.
- FIFO pointers are log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH. Count is log2(FIFO_DEPTH)+1 bits.

Optional Feature:
- Macro UART_TX_PARITY_EN.
- When defined:
  - CTRL bit2 = parity_en, bit3 = odd.
  - If parity_en, a PARITY state is inserted between DATA and STOP. It sends XOR of the data bits, or its inverse when odd, for BAUD+1 cycles.
- When undefined:
  - No PARITY state.
  - CTRL bits[3:2] read 0 and writes to them are ignored.

Decomposition:
- Package sysahb_uart_pkg holds:
  - register offsets (DATA/STATUS/BAUD/CTRL)
  - STATUS/CTRL bit positions
  - FSM state encoding (IDLE, START, DATA, PARITY, STOP)
- One sub-module, uart_tx_fifo:
  - Synchronous FIFO with push/pop/full/empty/count, parameterised by FIFO_DEPTH and 8-bit width.
  - Same clock and synchronous active-low reset.
  - Head data valid combinationally when !empty.

Test Plan:
- Reset, then write CTRL=1, DATA=0x55 → uart_txd shows start 0, then 1,0,1,0,1,0,1,0, then stop 1. Each bit is 67 cycles; total frame 670 cycles.
- BAUD=3, write DATA 0xA5 and 0x3C back-to-back, tx_en=1 → two frames of 40 cycles each with no idle gap between them. STATUS reads busy=1 during transmission, then empty=1, busy=0.
- tx_en=0, write 9 bytes with FIFO_DEPTH=8 → STATUS full=1, count=8, OVF=1. Write STATUS 0x8 → OVF=0. Enable → 8 frames emitted; 9th byte lost.
- CTRL=3, one byte → uart_irq=0 while sending. uart_irq=1 within 1 cycle after the STOP bit ends. Writing irq_en=0 → uart_irq=0 next cycle.
- Assert sys_resetn=0 mid DATA bit → next edge uart_txd=1, STATUS=empty, BAUD=66, no further frame.
- UART_TX_PARITY_EN defined, CTRL=0x5, BAUD=0, DATA=0x07 → 11-bit frame with parity bit 1. CTRL=0xD → parity bit 0.

Source files
------------

// File: rtl/sysahb_uart_pkg.sv
// Shared definitions for the system-bus transmit UART: register offsets,
// STATUS/CTRL bit positions and the transmitter state encoding.
package sysahb_uart_pkg;

  // Word offsets decoded from haddr[3:2]
  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_BAUD   = 2'd2;
  localparam logic [1:0] REG_CTRL   = 2'd3;

  // STATUS bit positions
  localparam int STAT_FULL      = 0;
  localparam int STAT_EMPTY     = 1;
  localparam int STAT_BUSY      = 2;
  localparam int STAT_OVF       = 3;
  localparam int STAT_COUNT_LSB = 8;

  // CTRL bit positions
  localparam int CTRL_TX_EN   = 0;
  localparam int CTRL_IRQ_EN  = 1;
  localparam int CTRL_PAR_EN  = 2;
  localparam int CTRL_PAR_ODD = 3;

  localparam int BAUD_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous TX byte FIFO. A push to a full FIFO is dropped (fullness is
// judged before any pop in the same cycle); head data is valid whenever the
// FIFO is not empty.
module uart_tx_fifo
  import sysahb_uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int DATA_W     = 8
) (
  input  logic                        sys_clk,
  input  logic                        sys_resetn,
  input  logic                        push,
  input  logic [DATA_W-1:0]           push_data,
  input  logic                        pop,
  output logic [DATA_W-1:0]           head_data,
  output logic                        full,
  output logic                        empty,
  output logic [$clog2(FIFO_DEPTH):0] count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q;
  logic [AW-1:0]     rd_ptr_q;
  logic [CW-1:0]     count_q;
  logic              push_ok;
  logic              pop_ok;

  assign full      = (count_q == FULL_CNT);
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign push_ok   = push & ~full;
  assign pop_ok    = pop & ~empty;
  assign head_data = mem[rd_ptr_q];

  // Pointer and occupancy tracking; pointers wrap modulo the power-of-two depth
  always_ff @(posedge sys_clk) begin
    if (!sys_resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage array; contents need no reset since occupancy gates every read
  always_ff @(posedge sys_clk) begin
    if (push_ok) mem[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/sysahb_uart_tx.sv
// Transmit-only 8N1 UART with an AHB-Lite slave port on the system bus.
// CPU writes to DATA are queued in uart_tx_fifo and shifted out LSB first on
// uart_txd; uart_irq signals "transmitter drained".
// Optional build macro UART_TX_PARITY_EN adds a parity bit (CTRL bit2 enable,
// bit3 odd); without it CTRL[3:2] read as zero.
module sysahb_uart_tx
  import sysahb_uart_pkg::*;
#(
  parameter int FIFO_DEPTH   = 8,
  parameter int BAUD_DIV_RST = 66
) (
  input  logic        sys_clk,
  input  logic        sys_resetn,
  input  logic        sysahb_hsel,
  input  logic [31:0] sysahb_haddr,
  input  logic [1:0]  sysahb_htrans,
  input  logic        sysahb_hwrite,
  input  logic [2:0]  sysahb_hsize,
  input  logic [31:0] sysahb_hwdata,
  output logic [31:0] sysahb_hrdata,
  output logic        sysahb_hready,
  output logic        sysahb_hresp,
  output logic        uart_txd,
  output logic        uart_irq
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [BAUD_W-1:0] BAUD_RST = BAUD_W'(BAUD_DIV_RST);

  // AHB data-phase stage
  logic              vld_p1;
  logic              write_p1;
  logic [1:0]        addr_p1;
  logic              wr_commit;

  // Programmer-visible registers
  logic [3:0]        ctrl_q;
  logic [BAUD_W-1:0] baud_q;
  logic              ovf_q;

  // Transmitter
  tx_state_e         state_q;
  tx_state_e         state_d;
  logic [BAUD_W-1:0] cnt_q;
  logic [BAUD_W-1:0] cnt_d;
  logic [2:0]        idx_q;
  logic [2:0]        idx_d;
  logic [7:0]        shift_q;
  logic [7:0]        shift_d;
  logic              txd_q;
  logic              txd_d;
  logic              irq_q;
  logic              load;
  logic              bit_end;

  // FIFO interface
  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [7:0]        fifo_head;
  logic [CW-1:0]     fifo_count;

  logic [31:0]       status_word;
  logic [31:0]       rd_word;
  logic              unused_bits;

  assign unused_bits = ^{sysahb_haddr[31:4], sysahb_haddr[1:0], sysahb_htrans[0],
                         sysahb_hsize, sysahb_hwdata[31:16]};

  assign sysahb_hready = 1'b1;
  assign sysahb_hresp  = 1'b0;

  // ---- stage p0 -> p1: address phase accepted, captured for the data phase
  // Data-phase valid flag (control, reset)
  always_ff @(posedge sys_clk) begin
    if (!sys_resetn) vld_p1 <= 1'b0;
    else             vld_p1 <= sysahb_hsel & sysahb_htrans[1] & sysahb_hready;
  end

  // Data-phase address/direction (qualified by vld_p1, so no reset needed)
  always_ff @(posedge sys_clk) begin
    addr_p1  <= sysahb_haddr[3:2];
    write_p1 <= sysahb_hwrite;
  end

  assign wr_commit = vld_p1 & write_p1;
  assign fifo_push = wr_commit & (addr_p1 == REG_DATA);

  // ---- stage p1: write commit at the end of the data phase
  // Register writes; OVF sets on a dropped push and clears on write-1 to STATUS
  always_ff @(posedge sys_clk) begin
    if (!sys_resetn) begin
      ctrl_q <= '0;
      baud_q <= BAUD_RST;
      ovf_q  <= 1'b0;
    end else begin
      if (wr_commit && addr_p1 == REG_BAUD) baud_q <= sysahb_hwdata[BAUD_W-1:0];
      if (wr_commit && addr_p1 == REG_CTRL) begin
        ctrl_q[CTRL_IRQ_EN:CTRL_TX_EN] <= sysahb_hwdata[CTRL_IRQ_EN:CTRL_TX_EN];
`ifdef UART_TX_PARITY_EN
        ctrl_q[CTRL_PAR_ODD:CTRL_PAR_EN] <= sysahb_hwdata[CTRL_PAR_ODD:CTRL_PAR_EN];
`endif
      end
      if (fifo_push && fifo_full) begin
        ovf_q <= 1'b1;
      end else if (wr_commit && addr_p1 == REG_STATUS && sysahb_hwdata[STAT_OVF]) begin
        ovf_q <= 1'b0;
      end
    end
  end

  uart_tx_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .DATA_W     (8)
  ) u_fifo (
    .sys_clk    (sys_clk),
    .sys_resetn (sys_resetn),
    .push       (fifo_push),
    .push_data  (sysahb_hwdata[7:0]),
    .pop        (fifo_pop),
    .head_data  (fifo_head),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .count      (fifo_count)
  );

  // STATUS word assembly
  always_comb begin
    status_word                             = '0;
    status_word[STAT_FULL]                  = fifo_full;
    status_word[STAT_EMPTY]                 = fifo_empty;
    status_word[STAT_BUSY]                  = (state_q != ST_IDLE);
    status_word[STAT_OVF]                   = ovf_q;
    status_word[STAT_COUNT_LSB +: CW]       = fifo_count;
  end

  // Read mux driven from the latched address, zero outside a read data phase
  always_comb begin
    rd_word = '0;
    if (vld_p1 && !write_p1) begin
      case (addr_p1)
        REG_STATUS: rd_word = status_word;
        REG_BAUD:   rd_word = {{(32-BAUD_W){1'b0}}, baud_q};
        REG_CTRL:   rd_word = {28'h0, ctrl_q};
        default:    rd_word = '0;
      endcase
    end
  end

  assign sysahb_hrdata = rd_word;

`ifdef UART_TX_PARITY_EN
  logic par_en_q;
  logic par_bit_q;

  function automatic logic parity_of(input logic [7:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

  // Parity mode and bit are frozen per frame when the byte is popped
  always_ff @(posedge sys_clk) begin
    if (load) begin
      par_en_q  <= ctrl_q[CTRL_PAR_EN];
      par_bit_q <= parity_of(fifo_head, ctrl_q[CTRL_PAR_ODD]);
    end
  end
`endif

  // ---- stage p1 -> serial: transmit sequencing
  // Next-state logic; BAUD is sampled each time a new bit starts
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    load    = 1'b0;
    txd_d   = 1'b1;
    bit_end = (cnt_q == '0);

    if (state_q != ST_IDLE && !bit_end) cnt_d = cnt_q - 1'b1;

    case (state_q)
      ST_IDLE: begin
        load = ctrl_q[CTRL_TX_EN] & ~fifo_empty;
      end
      ST_START: begin
        if (bit_end) begin
          state_d = ST_DATA;
          cnt_d   = baud_q;
          idx_d   = '0;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          cnt_d = baud_q;
          if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = par_en_q ? ST_PARITY : ST_STOP;
`else
            state_d = ST_STOP;
`endif
          end else begin
            idx_d   = idx_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
          end
        end
      end
      ST_PARITY: begin
        if (bit_end) begin
          state_d = ST_STOP;
          cnt_d   = baud_q;
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          if (ctrl_q[CTRL_TX_EN] && !fifo_empty) load    = 1'b1;
          else                                   state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Byte pop shared by IDLE start-up and STOP-to-START chaining
    if (load) begin
      state_d = ST_START;
      cnt_d   = baud_q;
      shift_d = fifo_head;
    end

    // Registered line level follows the state being entered
    case (state_d)
      ST_START:  txd_d = 1'b0;
      ST_DATA:   txd_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: txd_d = par_bit_q;
`endif
      default:   txd_d = 1'b1;
    endcase
  end

  assign fifo_pop = load;

  // Control state, line driver and interrupt (reset)
  always_ff @(posedge sys_clk) begin
    if (!sys_resetn) begin
      state_q <= ST_IDLE;
      txd_q   <= 1'b1;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      txd_q   <= txd_d;
      irq_q   <= ctrl_q[CTRL_IRQ_EN] & fifo_empty & (state_q == ST_IDLE);
    end
  end

  // Bit timer, bit index and shifter (always loaded before use)
  always_ff @(posedge sys_clk) begin
    cnt_q   <= cnt_d;
    idx_q   <= idx_d;
    shift_q <= shift_d;
  end

  assign uart_txd = txd_q;
  assign uart_irq = irq_q;

endmodule
